// File: rtl/vga_sync_monitor.sv
// Purpose: checks h/v sync, blank_n and RGB against VGA timing, recovers active-area
//          coordinates, declares lock after one clean frame and checksums each locked frame.
// Latency: 2 vga_clk cycles from pins to rx_*/error outputs; there is no backpressure.
module vga_sync_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CORDW    = 11
) (
    input  logic             vga_clk,
    input  logic             rst,
    input  logic             h_synch,
    input  logic             v_synch,
    input  logic             blank_n,
    input  logic [7:0]       r_in,
    input  logic [7:0]       g_in,
    input  logic [7:0]       b_in,
    output logic [CORDW-1:0] rx_x,
    output logic [CORDW-1:0] rx_y,
    output logic             rx_de,
    output logic             locked,
    output logic             h_err,
    output logic             v_err,
    output logic             de_err,
    output logic [7:0]       err_cnt,
    output logic [15:0]      frame_cnt,
    output logic [27:0]      frame_sum,
    output logic             frame_sum_vld
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] CNT_MAX = {CORDW{1'b1}};
    localparam logic [CORDW-1:0] H_LAST  = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST  = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_TMO   = CORDW'(2 * H_TOTAL);
    localparam logic [CORDW-1:0] V_TMO   = CORDW'(2 * V_TOTAL);
    localparam logic [CORDW-1:0] H_WS    = CORDW'(H_SYNC + H_BP);
    localparam logic [CORDW-1:0] H_WE    = CORDW'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [CORDW-1:0] V_WS    = CORDW'(V_SYNC + V_BP);
    localparam logic [CORDW-1:0] V_WE    = CORDW'(V_SYNC + V_BP + V_ACTIVE - 1);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // input sample stage and previous sync levels for edge detection
    logic             s_h_q, s_v_q, s_blank_q, ph_q, pv_q;
    logic [7:0]       s_r_q, s_g_q, s_b_q;

    // timing recovery state
    logic [CORDW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic             vs_pend_q, vs_pend_d;
    logic [1:0]       state_q, state_d;
    logic             bad_q, bad_d;
    logic [27:0]      acc_q, acc_d;

    // registered outputs
    logic [CORDW-1:0] rx_x_q, rx_y_q;
    logic             rx_de_q, h_err_q, v_err_q, de_err_q, frame_sum_vld_q;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [27:0]      frame_sum_q;

    // combinational decode of the sampled stream
    logic             hs_edge, vs_edge, vs_apply;
    logic             line_bad, frame_ok, h_tmo, v_tmo, win, is_locked;
    logic             h_err_d, v_err_d, de_err_d, rx_de_d, lost, sum_upd;
    logic [27:0]      pix_sum;

    assign hs_edge   = ph_q & ~s_h_q;
    assign vs_edge   = pv_q & ~s_v_q;
    // a vsync edge in the same cycle as the hsync edge applies to that line
    assign vs_apply  = hs_edge & (vs_pend_q | vs_edge);
    assign line_bad  = hs_edge & (hcnt_q != H_LAST);
    assign frame_ok  = (vcnt_q == V_LAST);
    // hcnt_d/vcnt_d are the position of the pixel currently held in the sample stage
    assign h_tmo     = (hcnt_d == H_TMO);
    assign v_tmo     = (vcnt_d == V_TMO);
    assign win       = (hcnt_d >= H_WS) && (hcnt_d <= H_WE) && (vcnt_d >= V_WS) && (vcnt_d <= V_WE);
    assign is_locked = (state_q == ST_LOCKED);
    assign h_err_d   = is_locked & (line_bad | h_tmo);
    assign v_err_d   = is_locked & ((vs_apply & ~frame_ok) | v_tmo);
    assign de_err_d  = is_locked & (s_blank_q != win);
    assign rx_de_d   = is_locked & win & s_blank_q;
    assign lost      = h_err_d | v_err_d;
    // a frame error on the closing edge suppresses that frame's checksum
    assign sum_upd   = is_locked & vs_apply & frame_ok & ~lost;
    assign pix_sum   = 28'(s_r_q) + 28'(s_g_q) + 28'(s_b_q);

    // register all pins once; edge detection looks only at these copies
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            s_h_q     <= 1'b0;
            s_v_q     <= 1'b0;
            s_blank_q <= 1'b0;
            s_r_q     <= 8'd0;
            s_g_q     <= 8'd0;
            s_b_q     <= 8'd0;
            ph_q      <= 1'b0;
            pv_q      <= 1'b0;
        end else begin
            s_h_q     <= h_synch;
            s_v_q     <= v_synch;
            s_blank_q <= blank_n;
            s_r_q     <= r_in;
            s_g_q     <= g_in;
            s_b_q     <= b_in;
            ph_q      <= s_h_q;
            pv_q      <= s_v_q;
        end
    end

    // pixel/line counters and the pending-vsync flag
    always_comb begin
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        vs_pend_d = vs_pend_q;
        if (hs_edge) begin
            hcnt_d = '0;
        end else if (hcnt_q != CNT_MAX) begin
            hcnt_d = hcnt_q + 1'b1;
        end
        if (vs_apply) begin
            vcnt_d    = '0;
            vs_pend_d = 1'b0;
        end else begin
            if (hs_edge && (vcnt_q != CNT_MAX)) begin
                vcnt_d = vcnt_q + 1'b1;
            end
            if (vs_edge) begin
                vs_pend_d = 1'b1;
            end
        end
    end

    // acquisition FSM: one full tracked frame with clean lines earns lock
    always_comb begin
        state_d = state_q;
        bad_d   = bad_q;
        case (state_q)
            ST_SEARCH: begin
                if (vs_apply) begin
                    state_d = ST_TRACK;
                    bad_d   = 1'b0;
                end
            end
            ST_TRACK: begin
                if (vs_apply) begin
                    if (frame_ok && !bad_q && !line_bad) begin
                        state_d = ST_LOCKED;
                    end
                    bad_d = 1'b0;
                end else if (line_bad) begin
                    bad_d = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (lost) begin
                    state_d = ST_SEARCH;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // checksum accumulator and saturating/wrapping statistics counters
    always_comb begin
        acc_d       = acc_q;
        err_cnt_d   = err_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (lost || vs_apply) begin
            acc_d = 28'd0;
        end else if (rx_de_d) begin
            acc_d = acc_q + pix_sum;
        end
        if ((h_err_d || v_err_d || de_err_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        if (sum_upd) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // state, counters and registered outputs
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            hcnt_q          <= '0;
            vcnt_q          <= '0;
            vs_pend_q       <= 1'b0;
            state_q         <= ST_SEARCH;
            bad_q           <= 1'b0;
            acc_q           <= 28'd0;
            rx_x_q          <= '0;
            rx_y_q          <= '0;
            rx_de_q         <= 1'b0;
            h_err_q         <= 1'b0;
            v_err_q         <= 1'b0;
            de_err_q        <= 1'b0;
            err_cnt_q       <= 8'd0;
            frame_cnt_q     <= 16'd0;
            frame_sum_q     <= 28'd0;
            frame_sum_vld_q <= 1'b0;
        end else begin
            hcnt_q          <= hcnt_d;
            vcnt_q          <= vcnt_d;
            vs_pend_q       <= vs_pend_d;
            state_q         <= state_d;
            bad_q           <= bad_d;
            acc_q           <= acc_d;
            rx_x_q          <= hcnt_d - H_WS;
            rx_y_q          <= vcnt_d - V_WS;
            rx_de_q         <= rx_de_d;
            h_err_q         <= h_err_d;
            v_err_q         <= v_err_d;
            de_err_q        <= de_err_d;
            err_cnt_q       <= err_cnt_d;
            frame_cnt_q     <= frame_cnt_d;
            frame_sum_vld_q <= sum_upd;
            if (sum_upd) begin
                frame_sum_q <= acc_q;
            end
        end
    end

    assign rx_x          = rx_x_q;
    assign rx_y          = rx_y_q;
    assign rx_de         = rx_de_q;
    assign locked        = is_locked;
    assign h_err         = h_err_q;
    assign v_err         = v_err_q;
    assign de_err        = de_err_q;
    assign err_cnt       = err_cnt_q;
    assign frame_cnt     = frame_cnt_q;
    assign frame_sum     = frame_sum_q;
    assign frame_sum_vld = frame_sum_vld_q;

endmodule
